// File: rtl/serial_parity_pkg.sv
`default_nettype none
// ============================================================================
// Module   : serial_parity_pkg
// Brief    : Shared frame-FSM state encodings and parity-mode constants.
// Revision : 1.0
// ============================================================================
package serial_parity_pkg;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_DATA   = 2'd1;
    localparam logic [1:0] ST_PARITY = 2'd2;
    localparam logic [1:0] ST_STOP   = 2'd3;

    localparam logic PAR_EVEN = 1'b0;
    localparam logic PAR_ODD  = 1'b1;

endpackage
`default_nettype wire

// File: rtl/serial_parity_frame_ctrl_parity_accum.sv
`default_nettype none
// ============================================================================
// Module   : parity_accum
// Brief    : 1-bit Moore running-parity register (1 = odd ones seen).
// Revision : 1.0
// ============================================================================
module parity_accum
    import serial_parity_pkg::*;
(
    input  logic clock,
    input  logic reset,
    input  logic clear,
    input  logic en,
    input  logic bit_in,
    output logic parity
);

    logic parity_q;
    logic parity_d;

    always_comb begin
        parity_d = parity_q;
        if (clear) begin
            parity_d = 1'b0;
        end else if (en && bit_in) begin
            parity_d = ~parity_q;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            parity_q <= 1'b0;
        end else begin
            parity_q <= parity_d;
        end
    end

    assign parity = parity_q;

endmodule
`default_nettype wire

// File: rtl/serial_parity_frame_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : serial_parity_frame_ctrl
// Brief    : Frame FSM for start/data(LSB-first)/parity/stop serial input.
// Revision : 1.0
// ============================================================================
module serial_parity_frame_ctrl
    import serial_parity_pkg::*;
#(
    parameter int DATA_BITS   = 8,
    parameter int PARITY_MODE = 0
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 input_bit,
    input  logic                 bit_valid,
    output logic                 busy,
    output logic                 parity,
    output logic                 frame_valid,
    output logic [DATA_BITS-1:0] data_out,
    output logic                 parity_err,
    output logic                 frame_err
);

    localparam int   c_cnt_w = $clog2(DATA_BITS + 1);
    localparam logic c_odd   = (PARITY_MODE != 0) ? PAR_ODD : PAR_EVEN;

    logic [1:0]           state_q, state_d;
    logic [c_cnt_w-1:0]   count_q, count_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic                 perr_pend_q, perr_pend_d;
    logic                 fvalid_q, fvalid_d;
    logic [DATA_BITS-1:0] dout_q, dout_d;
    logic                 perr_q, perr_d;
    logic                 ferr_q, ferr_d;
    logic                 acc_clear;
    logic                 acc_en;
    logic                 acc_parity;
    logic [DATA_BITS:0]   shift_ext;

    // Prepending the new bit and dropping bit 0 is a right shift that also works for DATA_BITS=1.
    assign shift_ext = {input_bit, shift_q};

    always_comb begin
        state_d     = state_q;
        count_d     = count_q;
        shift_d     = shift_q;
        perr_pend_d = perr_pend_q;
        fvalid_d    = 1'b0;
        dout_d      = dout_q;
        perr_d      = perr_q;
        ferr_d      = ferr_q;
        acc_clear   = 1'b0;
        acc_en      = 1'b0;
        if (bit_valid) begin
            case (state_q)
                ST_IDLE: begin
                    if (!input_bit) begin
                        state_d   = ST_DATA;
                        count_d   = '0;
                        acc_clear = 1'b1;
                    end
                end
                ST_DATA: begin
                    shift_d = shift_ext[DATA_BITS:1];
                    acc_en  = 1'b1;
                    count_d = count_q + c_cnt_w'(1);
                    if (count_q == c_cnt_w'(DATA_BITS - 1)) begin
                        state_d = ST_PARITY;
                    end
                end
                ST_PARITY: begin
                    perr_pend_d = input_bit ^ acc_parity ^ c_odd;
                    state_d     = ST_STOP;
                end
                ST_STOP: begin
                    fvalid_d = 1'b1;
                    dout_d   = shift_q;
                    perr_d   = perr_pend_q;
                    ferr_d   = ~input_bit;
                    state_d  = ST_IDLE;
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            count_q     <= '0;
            shift_q     <= '0;
            perr_pend_q <= 1'b0;
            fvalid_q    <= 1'b0;
            dout_q      <= '0;
            perr_q      <= 1'b0;
            ferr_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            count_q     <= count_d;
            shift_q     <= shift_d;
            perr_pend_q <= perr_pend_d;
            fvalid_q    <= fvalid_d;
            dout_q      <= dout_d;
            perr_q      <= perr_d;
            ferr_q      <= ferr_d;
        end
    end

    parity_accum u_parity_accum (
        .clock  (clock),
        .reset  (reset),
        .clear  (acc_clear),
        .en     (acc_en),
        .bit_in (input_bit),
        .parity (acc_parity)
    );

    assign busy        = (state_q != ST_IDLE);
    assign parity      = acc_parity;
    assign frame_valid = fvalid_q;
    assign data_out    = dout_q;
    assign parity_err  = perr_q;
    assign frame_err   = ferr_q;

endmodule
`default_nettype wire

// File: tb/tb_serial_parity_frame_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_serial_parity_frame_ctrl
// Brief    : Directed self-checking bench; even-mode and odd-mode instances.
// Revision : 1.0
// ============================================================================
module tb_serial_parity_frame_ctrl;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       input_bit = 1'b1;
    logic       bit_valid = 1'b0;

    logic       busy0, parity0, fv0, perr0, ferr0;
    logic [7:0] dout0;
    logic       busy1, parity1, fv1, perr1, ferr1;
    logic [7:0] dout1;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clock = ~clock;

    serial_parity_frame_ctrl #(.DATA_BITS(8), .PARITY_MODE(0)) u_even (
        .clock       (clock),
        .reset       (reset),
        .input_bit   (input_bit),
        .bit_valid   (bit_valid),
        .busy        (busy0),
        .parity      (parity0),
        .frame_valid (fv0),
        .data_out    (dout0),
        .parity_err  (perr0),
        .frame_err   (ferr0)
    );

    serial_parity_frame_ctrl #(.DATA_BITS(8), .PARITY_MODE(1)) u_odd (
        .clock       (clock),
        .reset       (reset),
        .input_bit   (input_bit),
        .bit_valid   (bit_valid),
        .busy        (busy1),
        .parity      (parity1),
        .frame_valid (fv1),
        .data_out    (dout1),
        .parity_err  (perr1),
        .frame_err   (ferr1)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One strobed bit; outputs are stable 1 time unit after the edge.
    task automatic send(input logic b);
        input_bit = b;
        bit_valid = 1'b1;
        @(posedge clock);
        #1;
    endtask

    // Three idle cycles with noise on the line, then the strobed bit.
    task automatic send_slow(input logic b);
        for (int k = 0; k < 3; k++) begin
            bit_valid = 1'b0;
            input_bit = 1'($urandom_range(0, 1));
            @(posedge clock);
            #1;
        end
        send(b);
    endtask

    task automatic send_frame(input logic [7:0] d, input logic rx_p, input logic stop_b);
        send(1'b0);
        for (int i = 0; i < 8; i++) send(d[i]);
        send(rx_p);
        send(stop_b);
    endtask

    task automatic idle_cycle();
        bit_valid = 1'b0;
        input_bit = 1'b1;
        @(posedge clock);
        #1;
    endtask

    initial begin
        logic [7:0] v;
        // Reset state
        repeat (2) @(posedge clock);
        #1;
        check("rst_busy", 32'(busy0), 32'd0);
        check("rst_parity", 32'(parity0), 32'd0);
        check("rst_fv", 32'(fv0), 32'd0);
        check("rst_dout", 32'(dout0), 32'd0);
        check("rst_errs", {30'd0, perr0, ferr0}, 32'd0);
        reset = 1'b0;
        idle_cycle();

        // 1: 0xA5 good frame
        send_frame(8'hA5, 1'b0, 1'b1);
        check("t1_fv", 32'(fv0), 32'd1);
        check("t1_dout", 32'(dout0), 32'hA5);
        check("t1_errs", {30'd0, perr0, ferr0}, 32'd0);
        check("t1_busy", 32'(busy0), 32'd0);
        idle_cycle();
        check("t1_fv_fall", 32'(fv0), 32'd0);

        // 2: wrong parity bit
        send_frame(8'hA5, 1'b1, 1'b1);
        check("t2_fv", 32'(fv0), 32'd1);
        check("t2_dout", 32'(dout0), 32'hA5);
        check("t2_errs", {30'd0, perr0, ferr0}, {30'd0, 2'b10});
        idle_cycle();

        // 3: stop bit 0, then line high must not start a frame
        send_frame(8'hA5, 1'b0, 1'b0);
        check("t3_fv", 32'(fv0), 32'd1);
        check("t3_errs", {30'd0, perr0, ferr0}, {30'd0, 2'b01});
        for (int i = 0; i < 3; i++) begin
            send(1'b1);
            check("t3_no_start", 32'(busy0), 32'd0);
        end
        check("t3_fv_fall", 32'(fv0), 32'd0);

        // 4: 0x3C with a strobe every 4th cycle and noise between strobes
        v = 8'h3C;
        send_slow(1'b0);
        for (int i = 0; i < 8; i++) begin
            send_slow(v[i]);
            if (i == 2) check("t4_par_mid", 32'(parity0), 32'd1);
        end
        check("t4_par_end", 32'(parity0), 32'd0);
        send_slow(1'b0);
        check("t4_par_hold", 32'(parity0), 32'd0);
        send_slow(1'b1);
        check("t4_fv", 32'(fv0), 32'd1);
        check("t4_dout", 32'(dout0), 32'h3C);
        check("t4_errs", {30'd0, perr0, ferr0}, 32'd0);
        bit_valid = 1'b0;
        @(posedge clock);
        #1;
        check("t4_fv_fall", 32'(fv0), 32'd0);

        // 5: reset mid-frame, then two back-to-back 0x81 frames
        send(1'b0);
        for (int i = 0; i < 4; i++) begin
            send(1'b1);
            if (i == 2) check("t5_par_pre", 32'(parity0), 32'd1);
        end
        check("t5_busy_pre", 32'(busy0), 32'd1);
        reset = 1'b1;
        bit_valid = 1'b1;
        @(posedge clock);
        #1;
        reset = 1'b0;
        check("t5_busy_rst", 32'(busy0), 32'd0);
        check("t5_par_rst", 32'(parity0), 32'd0);
        check("t5_fv_rst", 32'(fv0), 32'd0);
        check("t5_dout_rst", 32'(dout0), 32'd0);
        idle_cycle();
        send_frame(8'h81, 1'b0, 1'b1);
        check("t5_fv_a", 32'(fv0), 32'd1);
        check("t5_dout_a", 32'(dout0), 32'h81);
        send(1'b0);
        check("t5_fv_fall", 32'(fv0), 32'd0);
        check("t5_b2b_busy", 32'(busy0), 32'd1);
        for (int i = 0; i < 8; i++) send(v[i] & 1'b0 | ((i == 0 || i == 7) ? 1'b1 : 1'b0));
        send(1'b0);
        send(1'b1);
        check("t5_fv_b", 32'(fv0), 32'd1);
        check("t5_dout_b", 32'(dout0), 32'h81);
        check("t5_errs_b", {30'd0, perr0, ferr0}, 32'd0);
        idle_cycle();

        // 6: odd-parity instance, frame 0x01
        send_frame(8'h01, 1'b0, 1'b1);
        check("t6_odd_fv", 32'(fv1), 32'd1);
        check("t6_odd_dout", 32'(dout1), 32'h01);
        check("t6_odd_ok", 32'(perr1), 32'd0);
        check("t6_even_bad", 32'(perr0), 32'd1);
        idle_cycle();
        send_frame(8'h01, 1'b1, 1'b1);
        check("t6_odd_bad", 32'(perr1), 32'd1);
        check("t6_even_ok", 32'(perr0), 32'd0);
        check("t6_ferr", 32'(ferr1), 32'd0);
        idle_cycle();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
